// File: rtl/imem_loader.sv
// Instruction-memory writer: unpacks a length/data/checksum byte frame into
// little-endian 32-bit words and holds the CPU in reset until a frame verifies.
module imem_loader #(
    parameter int DEPTH_WORDS = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    output logic             we,
    output logic [31:0]      wAddr,
    output logic [31:0]      wData,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             err_len,
    output logic             err_chk,
    output logic [CNT_W-1:0] word_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
    } state_t;

    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(DEPTH_WORDS);

    state_t           state;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] word_idx;
    logic [7:0]       chk_sum;
    logic [1:0]       byte_idx;
    logic [23:0]      word_buf;
    logic             xfer;
    logic [CNT_W-1:0] len_full;

    // A byte moves only when the source offers it and the current state wants one.
    assign rx_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                      (state == S_DATA)   || (state == S_CHK);
    assign busy     = rx_ready || (state == S_WRITE);
    assign xfer     = rx_valid && rx_ready;
    assign len_full = CNT_W'({rx_data, len[7:0]});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            len        <= '0;
            word_idx   <= '0;
            chk_sum    <= 8'd0;
            byte_idx   <= 2'd0;
            word_buf   <= 24'd0;
            we         <= 1'b0;
            wAddr      <= 32'd0;
            wData      <= 32'd0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err_len    <= 1'b0;
            err_chk    <= 1'b0;
            word_count <= '0;
        end else begin
            we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_LEN_LO;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        err_len    <= 1'b0;
                        err_chk    <= 1'b0;
                        word_count <= '0;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len     <= CNT_W'(rx_data);
                        chk_sum <= rx_data;
                        state   <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len     <= len_full;
                        chk_sum <= chk_sum + rx_data;
                        if (len_full > MAX_LEN) begin
                            err_len <= 1'b1;
                            state   <= S_ERR;
                        end else if (len_full == '0) begin
                            state <= S_CHK;
                        end else begin
                            byte_idx <= 2'd0;
                            word_idx <= '0;
                            state    <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        chk_sum  <= chk_sum + rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= rx_data;
                            2'd1: word_buf[15:8]  <= rx_data;
                            2'd2: word_buf[23:16] <= rx_data;
                            default: begin
                                // Last byte goes straight into the write data register.
                                wData <= {rx_data, word_buf};
                                wAddr <= 32'({word_idx, 2'b00});
                                we    <= 1'b1;
                                state <= S_WRITE;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    word_idx   <= word_idx + CNT_W'(1);
                    word_count <= word_count + CNT_W'(1);
                    if (word_idx + CNT_W'(1) == len) state <= S_CHK;
                    else                             state <= S_DATA;
                end
                S_CHK: begin
                    if (xfer) begin
                        chk_sum <= chk_sum + rx_data;
                        if (chk_sum + rx_data == 8'd0) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            state    <= S_DONE;
                        end else begin
                            err_chk <= 1'b1;
                            state   <= S_ERR;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frames are driven byte by byte, expected memory writes
// are queued as {addr, data} and checked when the loader pulses we.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        we;
    logic [31:0] wAddr;
    logic [31:0] wData;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err_len;
    logic        err_chk;
    logic [15:0] word_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];

    imem_loader #(.DEPTH_WORDS(64), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid),
        .rx_data(rx_data), .rx_ready(rx_ready), .we(we), .wAddr(wAddr),
        .wData(wData), .cpu_hold(cpu_hold), .busy(busy), .done(done),
        .err_len(err_len), .err_chk(err_chk), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Write monitor: every we pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL write: unexpected write addr=%h data=%h", wAddr, wData);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({wAddr, wData} !== e) begin
                    n_bad++;
                    $display("FAIL write: got addr=%h data=%h, want addr=%h data=%h",
                             wAddr, wData, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (t < 50) begin
            @(negedge clk);
            if (rx_ready === 1'b1) break;
            t++;
        end
        if (t >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL handshake: byte %h not accepted within 50 cycles", b);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    // Sends the reference two-word frame with the given CHK byte.
    task automatic send_clean(input logic [7:0] chk, input bit stall, input bit inject);
        logic [7:0] fr [0:10];
        fr = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h75, 8'h00, 8'h00};
        fr[10] = chk;
        exp_q.push_back({32'h0000_0000, 32'h0050_0513});
        exp_q.push_back({32'h0000_0004, 32'h0075_0593});
        for (int i = 0; i < 11; i++) begin
            if (stall) begin
                int gap;
                gap = $urandom_range(0, 3);
                repeat (gap) begin @(posedge clk); #1; end
            end
            if (inject && i == 5) pulse_start();
            send_byte(fr[i]);
        end
        @(negedge clk);
    endtask

    task automatic check_queue_empty(input string name);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s: %0d expected writes never seen", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_flags(input string name, input logic e_done, input logic e_hold,
                               input logic e_len, input logic e_chk, input logic [15:0] e_cnt);
        n_cmp++;
        if ({done, cpu_hold, err_len, err_chk, busy, rx_ready} !== {e_done, e_hold, e_len, e_chk, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL %s flags: got done=%b hold=%b elen=%b echk=%b busy=%b rdy=%b, want %b %b %b %b 0 0",
                     name, done, cpu_hold, err_len, err_chk, busy, rx_ready, e_done, e_hold, e_len, e_chk);
        end
        n_cmp++;
        if (word_count !== e_cnt) begin
            n_bad++;
            $display("FAIL %s word_count: got %0d want %0d", name, word_count, e_cnt);
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({rx_ready, we, busy, done, err_len, err_chk, cpu_hold} !== 7'b0000001 ||
            wAddr !== 32'd0 || wData !== 32'd0 || word_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset: got rdy=%b we=%b busy=%b done=%b el=%b ec=%b hold=%b a=%h d=%h cnt=%0d",
                     rx_ready, we, busy, done, err_len, err_chk, cpu_hold, wAddr, wData, word_count);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        rx_valid = 1'b1; rx_data = 8'h55;
        repeat (2) begin @(posedge clk); #1; end
        rx_valid = 1'b0;
        n_cmp++;
        if (rx_ready !== 1'b0 || busy !== 1'b0 || cpu_hold !== 1'b1) begin
            n_bad++;
            $display("FAIL idle: got rdy=%b busy=%b hold=%b, want 0 0 1", rx_ready, busy, cpu_hold);
        end
    endtask

    task automatic test_clean_load();
        pulse_start();
        n_cmp++;
        if (busy !== 1'b1 || rx_ready !== 1'b1 || cpu_hold !== 1'b1) begin
            n_bad++;
            $display("FAIL armed: got busy=%b rdy=%b hold=%b, want 1 1 1", busy, rx_ready, cpu_hold);
        end
        send_clean(8'h89, 1'b0, 1'b0);
        check_queue_empty("clean_load");
        check_flags("clean_load", 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
    endtask

    task automatic test_empty_frame();
        pulse_start();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        @(negedge clk);
        check_queue_empty("empty_frame");
        check_flags("empty_frame", 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    endtask

    task automatic test_oversize();
        pulse_start();
        send_byte(8'h41); send_byte(8'h00);
        @(negedge clk);
        check_queue_empty("oversize");
        check_flags("oversize", 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
    endtask

    task automatic test_bad_checksum();
        pulse_start();
        send_clean(8'h88, 1'b0, 1'b0);
        check_queue_empty("bad_chk");
        check_flags("bad_chk", 1'b0, 1'b1, 1'b0, 1'b1, 16'd2);
        pulse_start();
        send_clean(8'h89, 1'b0, 1'b0);
        check_queue_empty("bad_chk_retry");
        check_flags("bad_chk_retry", 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
    endtask

    task automatic test_back_to_back_stall();
        pulse_start();
        send_clean(8'h89, 1'b1, 1'b1);
        check_queue_empty("stall");
        check_flags("stall", 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
    endtask

    task automatic test_reset_mid_frame();
        pulse_start();
        exp_q.push_back({32'h0000_0000, 32'h0050_0513});
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h13);
        send_byte(8'h05); send_byte(8'h50); send_byte(8'h00);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({rx_ready, we, busy, done, err_len, err_chk, cpu_hold} !== 7'b0000001 ||
            wAddr !== 32'd0 || wData !== 32'd0 || word_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_mid: got rdy=%b we=%b busy=%b done=%b el=%b ec=%b hold=%b a=%h d=%h cnt=%0d",
                     rx_ready, we, busy, done, err_len, err_chk, cpu_hold, wAddr, wData, word_count);
        end
        check_queue_empty("reset_mid_partial");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        pulse_start();
        send_clean(8'h89, 1'b0, 1'b0);
        check_queue_empty("reset_mid_reload");
        check_flags("reset_mid_reload", 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        test_reset();
        test_clean_load();
        test_empty_frame();
        test_oversize();
        test_bad_checksum();
        test_back_to_back_stall();
        test_reset_mid_frame();
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
